// File: rtl/fb_arbiter_pkg.sv
// Shared VGA timing constants, frame-buffer widths and arbiter types.
// The VGA constants match the ones vga_ctrl is built with.
package fb_arbiter_pkg;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_TOTAL  = 800;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_TOTAL  = 525;
   localparam int RGB_W        = 12;
   localparam int PIX_W        = 10;
   localparam int FB_X_W       = 8;
   localparam int FB_Y_W       = 7;

   typedef logic [RGB_W-1:0] rgb_t;

   typedef enum logic [1:0] {
      SLOT_NONE     = 2'd0,
      SLOT_LINE     = 2'd1,
      SLOT_PREFETCH = 2'd2
   } slot_e;

   typedef struct packed {
      logic              valid;
      logic [FB_X_W-1:0] x;
      logic [FB_Y_W-1:0] y;
      rgb_t              data;
   } wr_req_t;

   // Line that follows y, wrapping from the last line of the frame to 0.
   function automatic logic [PIX_W-1:0] next_row(input logic [PIX_W-1:0] y,
                                                  input logic [PIX_W-1:0] last);
      return (y == last) ? '0 : y + PIX_W'(1);
   endfunction
endpackage

// File: rtl/fb_addr_gen.sv
// Frame-buffer linear address y*FB_W + x, wrapped to ADDR_W bits.
module fb_addr_gen
   import fb_arbiter_pkg::*;
#(
   parameter int FB_W   = 160,
   parameter int ADDR_W = 15
) (
   input  logic [FB_X_W-1:0] x,
   input  logic [FB_Y_W-1:0] y,
   output logic [ADDR_W-1:0] addr
);
   logic [ADDR_W-1:0] xe, ye;

   assign xe = ADDR_W'(x);
   assign ye = ADDR_W'(y);

   generate
      if (FB_W == 160) begin : g_shift_add
         // 160 = 128 + 32
         assign addr = (ye << 7) + (ye << 5) + xe;
      end else begin : g_mul
         assign addr = (ye * ADDR_W'(FB_W)) + xe;
      end
   endgenerate
endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: fixed display-read slots for scan-out,
// every other cycle handed to the pixel writer.
module fb_arbiter
   import fb_arbiter_pkg::*;
#(
   parameter int H_ACTIVE    = VGA_H_ACTIVE,
   parameter int H_TOTAL     = VGA_H_TOTAL,
   parameter int V_ACTIVE    = VGA_V_ACTIVE,
   parameter int V_TOTAL     = VGA_V_TOTAL,
   parameter int SCALE_SHIFT = 2,
   parameter int ADDR_W      = 15
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [PIX_W-1:0]  pix_x,
   input  logic [PIX_W-1:0]  pix_y,
   output logic [RGB_W-1:0]  pixel,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [FB_X_W-1:0] wr_x,
   input  logic [FB_Y_W-1:0] wr_y,
   input  logic [RGB_W-1:0]  wr_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [RGB_W-1:0]  mem_wdata,
   input  logic [RGB_W-1:0]  mem_rdata,
   output logic              frame_tick,
   output logic [15:0]       wr_drop_cnt
);
   localparam int FB_W = H_ACTIVE >> SCALE_SHIFT;
   localparam int FB_H = V_ACTIVE >> SCALE_SHIFT;

   localparam logic [PIX_W-1:0] X_ACT  = PIX_W'(H_ACTIVE);
   localparam logic [PIX_W-1:0] X_PF   = PIX_W'(H_TOTAL - 4);
   localparam logic [PIX_W-1:0] X_LAST = PIX_W'(H_TOTAL - 1);
   localparam logic [PIX_W-1:0] Y_ACT  = PIX_W'(V_ACTIVE);
   localparam logic [PIX_W-1:0] Y_LAST = PIX_W'(V_TOTAL - 1);
   localparam logic [PIX_W-1:0] G_END  = PIX_W'(FB_W);
   // Slot, capture and load must fall on distinct phases, so SCALE_SHIFT >= 2.
   localparam logic [SCALE_SHIFT-1:0] P_SLOT = SCALE_SHIFT'(1);
   localparam logic [SCALE_SHIFT-1:0] P_LOAD = '1;

   logic [PIX_W-1:0]       g, g_nxt, ny;
   logic [SCALE_SHIFT-1:0] p;
   logic                   active, pf_line, grp_end, line_start;
   slot_e                  slot;
   logic [FB_X_W-1:0]      rd_x;
   logic [FB_Y_W-1:0]      rd_y;
   logic [ADDR_W-1:0]      rd_addr, wa_addr, addr_q;
   wr_req_t                wreq;
   logic                   accept, wr_ok;
   logic                   rd_pend, primed;
   rgb_t                   nxt, cur;

   assign g          = pix_x >> SCALE_SHIFT;
   assign p          = pix_x[SCALE_SHIFT-1:0];
   assign g_nxt      = g + PIX_W'(1);
   assign ny         = next_row(pix_y, Y_LAST);
   assign active     = (pix_x < X_ACT) && (pix_y < Y_ACT);
   assign pf_line    = ny < Y_ACT;
   assign line_start = (pix_x == X_LAST) && pf_line;
   assign grp_end    = (active && p == P_LOAD) || line_start;

   always_comb begin
      slot = SLOT_NONE;
      if (active && p == P_SLOT && g_nxt < G_END)
         slot = SLOT_LINE;
      else if (pix_x == X_PF && pf_line)
         slot = SLOT_PREFETCH;
   end

   // In-line slots fetch the next group; the prefetch fetches column 0 of the next line.
   always_comb begin
      rd_x = FB_X_W'(g_nxt);
      rd_y = FB_Y_W'(pix_y >> SCALE_SHIFT);
      if (slot == SLOT_PREFETCH) begin
         rd_x = '0;
         rd_y = FB_Y_W'(ny >> SCALE_SHIFT);
      end
   end

   fb_addr_gen #(.FB_W(FB_W), .ADDR_W(ADDR_W)) u_rd_addr (
      .x    (rd_x),
      .y    (rd_y),
      .addr (rd_addr)
   );

   assign wreq = '{valid: wr_valid, x: wr_x, y: wr_y, data: wr_data};

   fb_addr_gen #(.FB_W(FB_W), .ADDR_W(ADDR_W)) u_wr_addr (
      .x    (wreq.x),
      .y    (wreq.y),
      .addr (wa_addr)
   );

   assign wr_ok     = (wreq.x < FB_X_W'(FB_W)) && (wreq.y < FB_Y_W'(FB_H));
   assign wr_ready  = rstn && (slot == SLOT_NONE);
   assign accept    = wreq.valid && wr_ready;
   assign mem_we    = accept && wr_ok;
   assign mem_wdata = wreq.data;

   always_comb begin
      mem_addr = addr_q;
      if (slot != SLOT_NONE)
         mem_addr = rd_addr;
      else if (mem_we)
         mem_addr = wa_addr;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr_q      <= '0;
         rd_pend     <= 1'b0;
         nxt         <= '0;
         cur         <= '0;
         primed      <= 1'b0;
         frame_tick  <= 1'b0;
         wr_drop_cnt <= '0;
      end else begin
         addr_q     <= mem_addr;
         rd_pend    <= (slot != SLOT_NONE);
         frame_tick <= (pix_x == '0) && (pix_y == Y_ACT);
         if (rd_pend)
            nxt <= mem_rdata;
         if (grp_end)
            cur <= nxt;
         // Pixels stay blank after reset until a whole line has been prefetched.
         if (line_start)
            primed <= 1'b1;
         if (accept && !wr_ok && wr_drop_cnt != 16'hFFFF)
            wr_drop_cnt <= wr_drop_cnt + 16'd1;
      end
   end

   assign pixel = (active && primed) ? cur : '0;
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural BRAM and a pixel scoreboard.
module tb_fb_arbiter;
   logic        clk = 1'b0;
   logic        rstn;
   logic [9:0]  pix_x, pix_y;
   logic [11:0] pixel;
   logic        wr_valid, wr_ready;
   logic [7:0]  wr_x;
   logic [6:0]  wr_y;
   logic [11:0] wr_data;
   logic [14:0] mem_addr;
   logic        mem_we;
   logic [11:0] mem_wdata, mem_rdata;
   logic        frame_tick;
   logic [15:0] wr_drop_cnt;

   logic        rn = 1'b0, wv = 1'b0;
   logic [7:0]  wx = '0;
   logic [6:0]  wy = '0;
   logic [11:0] wd = '0;

   int          checks = 0, errors = 0;
   int          exp_drop = 0, we_cnt = 0;
   logic [11:0] pix_q[$];
   logic [11:0] ovr[int];
   logic [11:0] mem[0:32767];

   always #5 clk = ~clk;

   fb_arbiter dut (
      .clk         (clk),
      .rstn        (rstn),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pixel       (pixel),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_x        (wr_x),
      .wr_y        (wr_y),
      .wr_data     (wr_data),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .frame_tick  (frame_tick),
      .wr_drop_cnt (wr_drop_cnt)
   );

   initial for (int a = 0; a < 32768; a++) mem[a] = 12'(a);

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   function automatic int fa(input int x, input int y);
      return (y * 160 + x) % 32768;
   endfunction

   function automatic logic [11:0] ref_rd(input int a);
      if (ovr.exists(a)) return ovr[a];
      return 12'(a);
   endfunction

   function automatic bit slot_at(input int x, input int y);
      int ny;
      ny = (y == 524) ? 0 : y + 1;
      return (y < 480 && x < 640 && x % 4 == 1 && x / 4 + 1 < 160) || (x == 796 && ny < 480);
   endfunction

   function automatic int slot_addr(input int x, input int y);
      int ny;
      ny = (y == 524) ? 0 : y + 1;
      if (x == 796) return fa(0, ny / 4);
      return fa(x / 4 + 1, y / 4);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Apply staged inputs at the falling edge, then let combinational outputs settle.
   task automatic step(input int x, input int y);
      @(negedge clk);
      rstn     = rn;
      wr_valid = wv;
      wr_x     = wx;
      wr_y     = wy;
      wr_data  = wd;
      pix_x    = 10'(x);
      pix_y    = 10'(y);
      #1;
   endtask

   task automatic exp_pix(input int x, input int y, input bit primed);
      pix_q.push_back((x < 640 && y < 480 && primed) ? ref_rd(fa(x / 4, y / 4)) : 12'h000);
   endtask

   task automatic chk_pix(input string tag);
      logic [11:0] e;
      e = pix_q.pop_front();
      chk(tag, 32'(pixel), 32'(e));
   endtask

   initial begin
      rstn = 1'b0; pix_x = '0; pix_y = '0;
      wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;

      rn = 1'b0; wv = 1'b1; wx = 8'd5; wy = 7'd3; wd = 12'h123;
      for (int x = 780; x < 784; x++) begin
         step(x, 7);
         chk("rst_pixel", 32'(pixel), 32'h0);
         chk("rst_ready", 32'(wr_ready), 32'h0);
         chk("rst_we", 32'(mem_we), 32'h0);
         chk("rst_tick", 32'(frame_tick), 32'h0);
         chk("rst_drop", 32'(wr_drop_cnt), 32'h0);
      end

      rn = 1'b1; wv = 1'b0;
      for (int x = 784; x < 800; x++) begin
         step(x, 7);
         if (x == 796) begin
            chk("pf_ready", 32'(wr_ready), 32'h0);
            chk("pf_addr", 32'(mem_addr), 32'(fa(0, 2)));
         end
      end

      for (int x = 0; x < 800; x++) begin
         step(x, 8);
         exp_pix(x, 8, 1'b1);
         chk_pix("line8_pixel");
         chk("line8_ready", 32'(wr_ready), 32'(!slot_at(x, 8)));
         if (slot_at(x, 8)) chk("line8_rdaddr", 32'(mem_addr), 32'(slot_addr(x, 8)));
      end

      wv = 1'b1; wx = 8'd5; wy = 7'd3; wd = 12'h0F0; we_cnt = 0;
      for (int x = 1; x < 17; x++) begin
         step(x, 9);
         chk("wr_ready", 32'(wr_ready), 32'(!slot_at(x, 9)));
         if (mem_we) we_cnt++;
         if (wr_valid && !slot_at(x, 9)) begin
            chk("wr_we", 32'(mem_we), 32'h1);
            chk("wr_addr", 32'(mem_addr), 32'd485);
            chk("wr_wdata", 32'(mem_wdata), 32'h0F0);
            ovr[485] = 12'h0F0;
            wv = 1'b0;
         end
      end
      chk("wr_pulses", 32'(we_cnt), 32'd1);

      for (int x = 796; x < 800; x++) step(x, 11);
      for (int x = 0; x < 32; x++) begin
         step(x, 12);
         exp_pix(x, 12, 1'b1);
         chk_pix("wr_visible");
      end

      wv = 1'b1; wx = 8'd160; wy = 7'd0; wd = 12'hFFF;
      step(10, 500);
      chk("bad_ready", 32'(wr_ready), 32'h1);
      chk("bad_we", 32'(mem_we), 32'h0);
      chk("bad_drop_before", 32'(wr_drop_cnt), 32'h0);
      exp_drop = 1;
      wv = 1'b0;
      step(11, 500);
      chk("bad_drop_after", 32'(wr_drop_cnt), 32'h1);

      wv = 1'b1;
      for (int x = 0; x < 40; x++) begin
         step(x, 20);
         chk("held_drop", 32'(wr_drop_cnt), 32'(exp_drop));
         chk("held_we", 32'(mem_we), 32'h0);
         chk("held_ready", 32'(wr_ready), 32'(!slot_at(x, 20)));
         if (!slot_at(x, 20)) exp_drop++;
      end

      wx = 8'd5; wy = 7'd120;
      step(12, 500);
      chk("bad_y_we", 32'(mem_we), 32'h0);
      exp_drop++;

      wx = 8'd160; wy = 7'd0;
      for (int i = 0; i < 65536; i++) begin
         step(10, 500);
         if (exp_drop < 65535) exp_drop++;
      end
      wv = 1'b0;
      step(11, 500);
      chk("drop_sat", 32'(wr_drop_cnt), 32'(exp_drop));
      wv = 1'b1;
      step(10, 500);
      wv = 1'b0;
      step(11, 500);
      chk("drop_hold", 32'(wr_drop_cnt), 32'hFFFF);

      wv = 1'b1; wx = 8'd0; wy = 7'd0; wd = 12'hABC;
      step(20, 500);
      chk("w0_we", 32'(mem_we), 32'h1);
      chk("w0_addr", 32'(mem_addr), 32'h0);
      ovr[0] = 12'hABC;
      wx = 8'd1; wd = 12'h5A5;
      step(796, 479);
      chk("nopf_ready", 32'(wr_ready), 32'h1);
      chk("nopf_we", 32'(mem_we), 32'h1);
      chk("nopf_addr", 32'(mem_addr), 32'h1);
      ovr[1] = 12'h5A5;
      wv = 1'b0;
      for (int x = 797; x < 800; x++) step(x, 479);
      step(796, 524);
      chk("wrap_ready", 32'(wr_ready), 32'h0);
      chk("wrap_addr", 32'(mem_addr), 32'h0);
      for (int x = 797; x < 800; x++) step(x, 524);
      for (int x = 0; x < 8; x++) begin
         step(x, 0);
         exp_pix(x, 0, 1'b1);
         chk_pix("wrap_pixel");
      end

      step(799, 479);
      step(0, 479);
      step(1, 479);
      chk("tick_479", 32'(frame_tick), 32'h0);
      step(0, 480);
      chk("tick_pre", 32'(frame_tick), 32'h0);
      step(1, 480);
      chk("tick_pulse", 32'(frame_tick), 32'h1);
      step(2, 480);
      chk("tick_post", 32'(frame_tick), 32'h0);

      for (int x = 796; x < 800; x++) step(x, 99);
      for (int x = 0; x < 300; x++) begin
         step(x, 100);
         exp_pix(x, 100, 1'b1);
         chk_pix("pre_rst_pixel");
      end
      rn = 1'b0; wv = 1'b1; wx = 8'd5; wy = 7'd3; wd = 12'h777;
      for (int x = 300; x < 303; x++) begin
         step(x, 100);
         chk("mid_rst_pixel", 32'(pixel), 32'h0);
         chk("mid_rst_ready", 32'(wr_ready), 32'h0);
         chk("mid_rst_we", 32'(mem_we), 32'h0);
         chk("mid_rst_drop", 32'(wr_drop_cnt), 32'h0);
      end
      rn = 1'b1; wv = 1'b0;
      for (int x = 303; x < 800; x++) begin
         step(x, 100);
         exp_pix(x, 100, 1'b0);
         chk_pix("post_rst_blank");
      end
      for (int x = 0; x < 640; x++) begin
         step(x, 101);
         exp_pix(x, 101, 1'b1);
         chk_pix("post_rst_pixel");
      end
      chk("lost_write", 32'(mem[485]), 32'h0F0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
